uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: 8N1 serial line in, one byte out per frame, LSB first, fixed baud set by `CLKS_PER_BIT`. Counterpart of the team's UART transmitter. It sits between the board RX pin and the byte-level command logic, and shares the transmitter's `CLKS_PER_BIT` so both ends run at the same baud rate. It adds input synchronisation, mid-bit sampling, start-bit glitch rejection and framing-error detection with line-idle recovery.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per bit (e.g. 25 MHz / 115200). Legal minimum is 4.
- `i_Clock` in 1: system clock, rising edge.
- `i_Reset` in 1: reset, asynchronous, active-low.
- `i_RX_Serial` in 1: asynchronous serial line, idle high.
- `o_RX_DV` out 1: one-cycle pulse; `o_RX_Byte` is valid on this cycle and stays valid afterwards.
- `o_RX_Byte` out 8: last correctly framed byte. Held until the next good frame.
- `o_RX_Frame_Err` out 1: one-cycle pulse when the stop bit samples low.
- `o_RX_Active` out 1: high from start-bit detection until the FSM returns to IDLE.

## Operation
- **Synchroniser.** Two-flop synchroniser on `i_RX_Serial`. Both flops reset to 1. All logic uses the second-stage output, called `rx_s`.
- **Definitions.**
  - H = (CLKS_PER_BIT-1)/2, integer division; H = 108 for the default.
  - Bit counter width is clog2(CLKS_PER_BIT)+1 bits.
  - 3-bit bit index.
  - 8-bit shift/holding register.
- **IDLE.**
  - Counter = 0, index = 0.
  - If `rx_s` == 0: go to START and set `o_RX_Active` = 1.
- **START.**
  - If counter < H: increment the counter.
  - At counter == H, with `rx_s` == 0: go to DATA, counter = 0.
  - At counter == H, with `rx_s` == 1: glitch. Go to IDLE, `o_RX_Active` = 0, no pulse of any kind.
- **DATA.**
  - If counter < CLKS_PER_BIT-1: increment the counter.
  - Otherwise: counter = 0 and `rx_s` is stored into bit[index].
  - If index < 7: index + 1 and stay in DATA.
  - Else: index = 0 and go to STOP.
- **STOP.**
  - Count the same way as DATA. At counter == CLKS_PER_BIT-1, sample `rx_s`.
  - Sample 1: copy the assembled byte to `o_RX_Byte`, pulse `o_RX_DV`, go to IDLE, `o_RX_Active` = 0.
  - Sample 0: pulse `o_RX_Frame_Err`, leave `o_RX_Byte` unchanged, go to WAIT_IDLE.
- **WAIT_IDLE.**
  - Break/error recovery state; `o_RX_Active` stays 1.
  - On `rx_s` == 1: go to IDLE, `o_RX_Active` = 0.
- **Illegal state encoding.** Go to IDLE on the next clock.
- **Back-to-back frames.** STOP returns to IDLE at stop-bit centre, so a start bit arriving immediately after the stop bit is detected with no lost frame.
- **Reset**, asynchronous, also mid-frame:
  - state = IDLE, counter = 0, index = 0.
  - Synchroniser flops = 1, shift register = 0.
  - `o_RX_Byte` = 0x00; `o_RX_DV`, `o_RX_Frame_Err`, `o_RX_Active` = 0.
  - No pulse is issued for a partial frame.

## Timing
- Edge 0 is the first rising edge at which `i_RX_Serial` is sampled low.
  - `rx_s` is low after edge 1.
  - IDLE→START on edge 2; `o_RX_Active` is high after edge 2.
  - START→DATA on edge 3+H.
  - Data bit n is sampled on edge 3+H+(n+1)·CLKS_PER_BIT.
  - Stop bit is sampled on edge 3+H+9·CLKS_PER_BIT.
- `o_RX_DV` and `o_RX_Frame_Err` are high for exactly the one cycle following the stop-sample edge. They are never high together.
- Default latency: `o_RX_DV` is high after edge 2064 (3+108+1953). Sample points fall within ±3 clocks of bit centre.
- Tolerance: the sample point drifts ≤ 1 clock per bit from synchroniser quantisation. Frames from the matching transmitter must always decode.

## Test plan
- Hold reset low, toggle `i_RX_Serial` -> all outputs 0, `o_RX_Byte` = 0x00. Release reset -> outputs stay 0 while the line stays high.
- Send 0xA5 at 217 clk/bit -> `o_RX_DV` pulses once, high after edge 2064. `o_RX_Byte` = 0xA5 and holds afterwards. `o_RX_Active` rises after edge 2 and falls with DV.
- Send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three DV pulses carrying 0x00, 0xFF, 0x3C in order. `o_RX_Frame_Err` never asserts.
- Drive the line low for 50 clocks, then high -> no DV, no Frame_Err. `o_RX_Active` high for ~H cycles then 0. A following 0x5A frame decodes correctly.
- Send 0x81 with the stop bit low, then hold low for 3000 clocks -> one Frame_Err pulse, no DV. `o_RX_Byte` keeps its previous value and `o_RX_Active` stays high. After the line goes high, the next frame 0x42 decodes.
- Assert reset during data bit 4 of a frame, release before the line idles -> no pulse of either kind. The receiver then decodes a subsequent full 0xC3 frame. Loopback from the team's transmitter with random bytes matches byte-for-byte.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, fixed baud set by CLKS_PER_BIT.
// The serial line is double-flopped into the clock domain. The start bit is
// re-checked at its centre so that short glitches are rejected. Data and
// stop bits are sampled one bit period apart from that centre. A low stop
// bit raises a framing error, and the receiver then waits for the line to
// return high before it hunts for the next start bit.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  // Half a bit period, used to move from the start edge to the start-bit centre.
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       byte_q;
  logic             dv_q;
  logic             ferr_q;
  logic             active_q;

  // Two-flop synchroniser. It resets to the idle (high) line level.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The current sample is written into the bit position the index points at.
  always_comb begin
    shift_d         = shift_q;
    shift_d[idx_q]  = rx_s_q;
  end

  // Frame FSM. All outputs are registered, and the pulses last one cycle.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s_q) begin
            state_q  <= S_START;
            active_q <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q < HALF_BIT) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else if (!rx_s_q) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
          end else begin
            // The line went back high before the centre of the start bit,
            // so the low level was a glitch.
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            active_q <= 1'b0;
          end
        end
        S_DATA: begin
          if (cnt_q < LAST_CNT) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (idx_q < 3'd7) begin
              idx_q <= idx_q + 3'd1;
            end else begin
              idx_q   <= '0;
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (cnt_q < LAST_CNT) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            cnt_q <= '0;
            // Returning to IDLE at the stop-bit centre lets a start bit that
            // follows the stop bit directly be caught.
            if (rx_s_q) begin
              byte_q   <= shift_q;
              dv_q     <= 1'b1;
              state_q  <= S_IDLE;
              active_q <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          // A break or bad frame: wait for the line to idle before rearming.
          if (rx_s_q) begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          idx_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Frame_Err = ferr_q;
  assign o_RX_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and records every cycle.
// A frame-level timing model, built from bit-centre arithmetic on the
// recorded line, predicts the outputs for each cycle. Literal latencies and
// byte lists pin that model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB  = 217;
  localparam int H    = (CPB - 1) / 2;
  localparam int MAXC = 60000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dv, ferr, act;
  logic [7:0] rbyte;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock(clk), .i_Reset(rst_n), .i_RX_Serial(rx),
    .o_RX_DV(dv), .o_RX_Byte(rbyte), .o_RX_Frame_Err(ferr), .o_RX_Active(act)
  );

  always #5 clk = ~clk;

  // Per-edge record: the inputs seen at edge k and the outputs after edge k.
  logic       line_a [MAXC];
  logic       rst_a  [MAXC];
  logic       dv_a   [MAXC];
  logic       ferr_a [MAXC];
  logic       act_a  [MAXC];
  logic [7:0] byte_a [MAXC];
  // Model expectations
  logic       e_dv   [MAXC];
  logic       e_ferr [MAXC];
  logic       e_act  [MAXC];
  logic [7:0] e_byte [MAXC];

  int ncyc = 0;
  int checks = 0;
  int passes = 0;
  logic [7:0] lit_q [$];
  logic [7:0] mdl_q [$];
  logic [7:0] dut_q [$];
  int mdl_ferr = 0;
  int dut_ferr = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ncyc < MAXC) begin
        line_a[ncyc] = rx;
        rst_a[ncyc]  = rst_n;
        dv_a[ncyc]   = dv;
        ferr_a[ncyc] = ferr;
        act_a[ncyc]  = act;
        byte_a[ncyc] = rbyte;
      end
      ncyc = ncyc + 1;
    end
  end

  initial begin
    #(MAXC * 10 + 5000);
    $display("FAIL watchdog: simulation still running at cycle %0d", ncyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // The value the receiver sees at edge k is the line level two edges
  // earlier. A reset holding the synchroniser within that window reads as idle.
  function automatic logic seen(input int k);
    if (k < 2) return 1'b1;
    if (rst_a[k-1] && rst_a[k-2]) return line_a[k-2];
    return 1'b1;
  endfunction

  task automatic run_model(input int n);
    int k, d, g, s, w, end_e, j, outcome;
    logic [7:0] hold, b;
    logic aborted;
    for (int i = 0; i < n; i++) begin
      e_dv[i] = 1'b0; e_ferr[i] = 1'b0; e_act[i] = 1'b0; e_byte[i] = 8'h00;
    end
    k = 0;
    hold = 8'h00;
    while (k < n) begin
      if (!rst_a[k]) begin
        hold = 8'h00;
        k++;
      end else if (seen(k)) begin
        e_byte[k] = hold;
        k++;
      end else begin
        // Start detected at edge d. Outcome: 0 truncated, 1 glitch, 2 ok, 3 error.
        d = k;
        g = d + 1 + H;
        s = g + 9 * CPB;
        b = 8'h00;
        outcome = 0;
        end_e = n;
        if (g < n) begin
          if (seen(g)) begin
            outcome = 1;
            end_e = g;
          end else if (s < n) begin
            for (int i = 0; i < 8; i++) b[i] = seen(g + (i + 1) * CPB);
            if (seen(s)) begin
              outcome = 2;
              end_e = s;
            end else begin
              outcome = 3;
              w = s + 1;
              while (w < n && !seen(w)) w++;
              end_e = w;
            end
          end
        end
        aborted = 1'b0;
        j = d;
        while (j <= end_e && j < n) begin
          if (!rst_a[j]) begin
            aborted = 1'b1;
            break;
          end
          e_byte[j] = hold;
          e_act[j]  = (j < end_e);
          j++;
        end
        if (aborted) begin
          k = j;
        end else begin
          if (outcome == 2) begin
            e_dv[s] = 1'b1;
            hold = b;
            e_byte[s] = b;
            mdl_q.push_back(b);
          end else if (outcome == 3) begin
            e_ferr[s] = 1'b1;
            mdl_ferr++;
          end
          k = end_e + 1;
        end
      end
    end
  endtask

  initial begin
    int e_a5, e_gl, e_81, n, shown;
    logic [7:0] rb;
    rx = 1'b1;
    rst_n = 1'b0;
    // Reset held while the line toggles
    for (int i = 0; i < 20; i++) begin
      tick();
      rx = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    rx = 1'b1;
    tick();
    chk("reset_outputs", int'({dv, ferr, act, rbyte}), 0);
    rst_n = 1'b1;
    idle(40);
    chk("idle_after_reset", int'({dv, ferr, act, rbyte}), 0);

    e_a5 = ncyc;
    send(8'hA5, 1'b1);
    lit_q.push_back(8'hA5);
    idle(60);

    send(8'h00, 1'b1); lit_q.push_back(8'h00);
    send(8'hFF, 1'b1); lit_q.push_back(8'hFF);
    send(8'h3C, 1'b1); lit_q.push_back(8'h3C);
    idle(60);

    // Start-bit glitch, shorter than half a bit
    e_gl = ncyc;
    rx = 1'b0;
    repeat (50) tick();
    idle(300);
    send(8'h5A, 1'b1); lit_q.push_back(8'h5A);
    idle(60);

    // Low stop bit followed by a long break
    e_81 = ncyc;
    send(8'h81, 1'b0);
    repeat (3000) tick();
    idle(200);
    send(8'h42, 1'b1); lit_q.push_back(8'h42);
    idle(60);

    // Reset pulse in the middle of data bit 4 of frame 0xF5
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx = (8'hF5 >> i) & 8'h01;
      repeat (CPB) tick();
    end
    rx = 1'b1;
    repeat (CPB / 2) tick();
    rst_n = 1'b0;
    repeat (20) tick();
    rst_n = 1'b1;
    repeat (CPB - CPB / 2 - 20 + 4 * CPB) tick();
    idle(100);
    send(8'hC3, 1'b1); lit_q.push_back(8'hC3);
    idle(60);

    // Random bytes with random gaps, including none at all
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      idle($urandom_range(0, 30));
      send(rb, 1'b1);
      lit_q.push_back(rb);
    end
    idle(100);

    chk("cycle_budget", int'(ncyc <= MAXC), 1);
    n = (ncyc < MAXC) ? ncyc : MAXC;
    run_model(n);

    // Literal timing pins, applied to both the model and the DUT
    chk("model_a5_dv_at_2064", int'(e_dv[e_a5 + 2064]), 1);
    chk("a5_dv_at_2064", int'(dv_a[e_a5 + 2064]), 1);
    chk("a5_dv_not_at_2063", int'(dv_a[e_a5 + 2063]), 0);
    chk("a5_byte_at_dv", int'(byte_a[e_a5 + 2064]), 8'hA5);
    chk("a5_byte_held", int'(byte_a[e_a5 + 2064 + 50]), 8'hA5);
    chk("a5_active_not_after_e1", int'(act_a[e_a5 + 1]), 0);
    chk("a5_active_after_e2", int'(act_a[e_a5 + 2]), 1);
    chk("a5_active_falls_with_dv", int'(act_a[e_a5 + 2064]), 0);
    chk("glitch_active_before_centre", int'(act_a[e_gl + 2 + H]), 1);
    chk("glitch_active_cleared", int'(act_a[e_gl + 3 + H]), 0);
    chk("ferr_at_2064", int'(ferr_a[e_81 + 2064]), 1);
    chk("ferr_no_dv", int'(dv_a[e_81 + 2064]), 0);
    chk("ferr_active_in_break", int'(act_a[e_81 + 2064 + 1500]), 1);
    chk("ferr_byte_kept", int'(byte_a[e_81 + 2064 + 1500]), 8'h5A);

    // Cycle-by-cycle comparison against the model
    shown = 0;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (dv_a[k] === e_dv[k] && ferr_a[k] === e_ferr[k] &&
          act_a[k] === e_act[k] && byte_a[k] === e_byte[k]) begin
        passes++;
      end else if (shown < 10) begin
        shown++;
        $display("FAIL cycle %0d: dv/ferr/act/byte got %b/%b/%b/%h expected %b/%b/%b/%h",
                 k, dv_a[k], ferr_a[k], act_a[k], byte_a[k], e_dv[k], e_ferr[k], e_act[k], e_byte[k]);
      end
      if (dv_a[k] === 1'b1) dut_q.push_back(byte_a[k]);
      if (ferr_a[k] === 1'b1) dut_ferr++;
    end

    // Byte streams and error counts against the literal stimulus list
    chk("model_dv_count", mdl_q.size(), lit_q.size());
    chk("dut_dv_count", dut_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size(); i++) begin
      if (i < mdl_q.size()) chk($sformatf("model_byte_%0d", i), int'(mdl_q[i]), int'(lit_q[i]));
      if (i < dut_q.size()) chk($sformatf("dut_byte_%0d", i), int'(dut_q[i]), int'(lit_q[i]));
    end
    chk("model_ferr_count", mdl_ferr, 1);
    chk("dut_ferr_count", dut_ferr, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
